// File: rtl/mem_stream_port.sv
// ---------------------------------------------------------------------------
// mem_stream_port
//
// Bus initiator sitting on the Memory port (the side the Processor normally
// drives).  Two transfer modes:
//   LOAD (mode=0): accepts a valid/ready word stream and writes the words to
//                  consecutive word addresses starting at base_addr.
//   DUMP (mode=1): reads consecutive words starting at base_addr and emits
//                  them on a valid/ready stream.
//
// Ports
//   clk, rst               clock (rising edge), synchronous active-high reset
//   start, mode            start a transfer (sampled only when idle), direction
//   base_addr, word_count  first byte address (low 2 bits ignored), word count
//   in_valid/in_data/in_ready     LOAD input stream
//   out_valid/out_data/out_ready  DUMP output stream
//   busy, done             busy outside IDLE; one-cycle pulse on completion
//   MemRead, MemWrite, MemAddr, WriteMem, MemOut   memory bus
//   dbg_state_o            current FSM state, for observation only
//
// Stream handshake: a word moves on a cycle where valid and ready are both
// high at the rising clock edge.  Once out_valid is raised, out_valid and
// out_data stay stable until that handshake; in_ready does not depend on
// in_valid.
// ---------------------------------------------------------------------------
module mem_stream_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] WriteMem,
    input  logic [DATA_W-1:0] MemOut,
    output logic [2:0]        dbg_state_o
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LFLUSH = 3'd2,
        S_RD_REQ = 3'd3,
        S_RD_OUT = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   write_mem_q, write_mem_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                in_ready_c;
    logic                mem_read_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            lat_q       <= '0;
            mem_write_q <= 1'b0;
            wr_addr_q   <= '0;
            write_mem_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            lat_q       <= lat_d;
            mem_write_q <= mem_write_d;
            wr_addr_q   <= wr_addr_d;
            write_mem_q <= write_mem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        lat_d       = lat_q;
        mem_write_d = 1'b0;
        wr_addr_d   = '0;
        write_mem_d = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_ready_c  = 1'b0;
        mem_read_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                lat_d = '0;
                if (start) begin
                    addr_d  = base_addr & ~(ADDR_W'(3));
                    count_d = word_count;
                    if (word_count == '0) begin
                        state_d = S_FIN;
                    end else if (mode) begin
                        state_d = S_RD_REQ;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    // The write is issued from registers in the following cycle.
                    mem_write_d = 1'b1;
                    wr_addr_d   = addr_q;
                    write_mem_d = in_data;
                    addr_d      = addr_q + ADDR_W'(4);
                    if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
                    end
                    if (count_q <= CNT_W'(1)) begin
                        state_d = S_LFLUSH;
                    end
                end
            end

            // The registered write of the last accepted word is on the bus now.
            S_LFLUSH: begin
                state_d = S_FIN;
            end

            S_RD_REQ: begin
                mem_read_c = 1'b1;
                if (lat_q == LAT_W'(RD_LAT - 1)) begin
                    out_data_d  = MemOut;
                    out_valid_d = 1'b1;
                    lat_d       = '0;
                    state_d     = S_RD_OUT;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            S_RD_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    addr_d      = addr_q + ADDR_W'(4);
                    if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
                    end
                    state_d = (count_q <= CNT_W'(1)) ? S_FIN : S_RD_REQ;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready    = in_ready_c;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign MemRead     = mem_read_c;
    assign MemWrite    = mem_write_q;
    // Reads and writes never overlap, so the bus address is chosen by MemRead.
    assign MemAddr     = mem_read_c ? addr_q : wr_addr_q;
    assign WriteMem    = write_mem_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stream_port.sv
module tb_mem_stream_port;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 12;
  localparam int RD_LAT = 1;
  localparam int WORDS  = 2048;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              done;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] WriteMem;
  logic [DATA_W-1:0] MemOut;
  logic [2:0]        dbg_state;

  mem_stream_port #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr),
    .WriteMem(WriteMem), .MemOut(MemOut), .dbg_state_o(dbg_state)
  );

  // ---------------- memory attached to the bus ----------------
  logic [DATA_W-1:0] mem [WORDS];
  logic              pre_en = 1'b0;
  logic [10:0]       pre_idx = '0;
  logic [DATA_W-1:0] pre_val = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (MemWrite) mem[MemAddr[12:2]] <= WriteMem;
  end
  assign MemOut = mem[MemAddr[12:2]];

  // ---------------- reference model + scoreboard ----------------
  logic [DATA_W-1:0]        ref_mem [WORDS];
  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
  logic [DATA_W-1:0]        exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int rd_hs = 0;
  logic [ADDR_W-1:0] rd_addr_exp = '0;
  bit dump_active = 1'b0;
  bit stall_prev = 1'b0;
  logic [DATA_W-1:0] stall_data = '0;

  function automatic logic [10:0] widx(input logic [ADDR_W-1:0] a);
    return a[12:2];
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] ew;
    logic [DATA_W-1:0] ed;
    if (MemRead || MemWrite) begin
      checks++;
      if (MemRead && MemWrite) begin
        errors++;
        $display("FAIL rd_wr_overlap got MemRead=1 MemWrite=1 exp not both");
      end
    end
    if (MemWrite) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_write got addr=%h data=%h exp no write", MemAddr, WriteMem);
      end else begin
        ew = exp_wr_q.pop_front();
        if ({MemAddr, WriteMem} !== ew) begin
          errors++;
          $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                   MemAddr, WriteMem, ew[63:32], ew[31:0]);
        end
      end
    end
    if (MemRead) begin
      checks++;
      if (!dump_active || MemAddr !== rd_addr_exp) begin
        errors++;
        $display("FAIL read_addr got %h exp %h (dump_active=%0d)", MemAddr, rd_addr_exp, dump_active);
      end
    end
    if (stall_prev) begin
      checks++;
      if (!out_valid || out_data !== stall_data) begin
        errors++;
        $display("FAIL stall_stable got valid=%0b data=%h exp valid=1 data=%h", out_valid, out_data, stall_data);
      end
    end
    if (out_valid) begin
      checks++;
      if (!dump_active) begin
        errors++;
        $display("FAIL spurious_out_valid got 1 exp 0");
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_out got data=%h exp none", out_data);
        end else begin
          ed = exp_q.pop_front();
          if (out_data !== ed) begin
            errors++;
            $display("FAIL out_data got %h exp %h", out_data, ed);
          end
        end
        rd_hs++;
        rd_addr_exp = rd_addr_exp + 32'd4;
      end else if (MemRead) begin
        errors++;
        $display("FAIL read_during_stall got MemRead=1 exp 0");
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input logic m, input logic [ADDR_W-1:0] b, input int n);
    start = 1'b1;
    mode = m;
    base_addr = b;
    word_count = n[CNT_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for the done pulse; exp_w > 0 also checks how many cycles it took.
  task automatic wait_done(input string tag, input int exp_w);
    int w = 0;
    bit seen = 1'b0;
    while (!seen && w < 300) begin
      @(negedge clk);
      w++;
      seen = done;
      @(posedge clk); #1;
    end
    exp_done++;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout got no done exp done", tag);
    end else if (exp_w > 0 && w != exp_w) begin
      errors++;
      $display("FAIL %s_done_latency got %0d exp %0d", tag, w, exp_w);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_fin got done=%0b busy=%0b exp 0 0", tag, done, busy);
    end
    @(posedge clk); #1;
  endtask

  // vmode: 0 = in_valid held high, 1 = toggling, 2 = random
  task automatic run_load(input string tag, input logic [ADDR_W-1:0] b, input int n, input int vmode);
    int acc = 0;
    int cyc = 0;
    logic [ADDR_W-1:0] eb;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    eb = b & 32'hFFFF_FFFC;
    start_xfer(1'b0, b, n);
    while (acc < n && cyc < 4 * n + 50) begin
      if (vmode == 0) in_valid = 1'b1;
      else if (vmode == 1) in_valid = (cyc % 2 == 0);
      else in_valid = 1'($urandom_range(0, 1));
      d = $urandom;
      in_data = d;
      @(negedge clk);
      if (in_valid && in_ready) begin
        a = eb + 32'(4 * acc);
        exp_wr_q.push_back({a, d});
        ref_mem[widx(a)] = d;
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (acc != n || (vmode == 0 && cyc != n)) begin
      errors++;
      $display("FAIL %s_accept got %0d words in %0d cycles exp %0d", tag, acc, cyc, n);
    end
    wait_done(tag, (vmode == 0) ? 2 : 0);
    checks++;
    if (exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes_missing got %0d pending exp 0", tag, exp_wr_q.size());
      exp_wr_q.delete();
    end
  endtask

  // rmode: 0 = out_ready high, 1 = random, 2 = low for first 5 cycles
  task automatic run_dump(input string tag, input logic [ADDR_W-1:0] b, input int n,
                          input int rmode, input bit poke_start);
    int cyc = 0;
    logic [ADDR_W-1:0] eb;
    eb = b & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[widx(eb + 32'(4 * i))]);
    rd_hs = 0;
    rd_addr_exp = eb;
    dump_active = 1'b1;
    start_xfer(1'b1, b, n);
    while (rd_hs < n && cyc < 8 * n + 60) begin
      if (rmode == 0) out_ready = 1'b1;
      else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = (cyc >= 5);
      if (poke_start && cyc == 2) begin
        start = 1'b1; mode = 1'b0; word_count = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (rd_hs != n || (rmode == 0 && cyc != 2 * n)) begin
      errors++;
      $display("FAIL %s_handshakes got %0d in %0d cycles exp %0d", tag, rd_hs, cyc, n);
    end
    wait_done(tag, (rmode == 0) ? 1 : 0);
    dump_active = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_words_missing got %0d pending exp 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int dc;
    logic [DATA_W-1:0] d;

    // preload memory (and its model) while held in reset
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < WORDS; i++) begin
      pre_en = 1'b1;
      pre_idx = 11'(i);
      pre_val = $urandom;
      ref_mem[i] = pre_val;
      @(posedge clk); #1;
    end
    pre_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_data, busy, done, MemRead, MemWrite, MemAddr, WriteMem} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero exp all 0 (busy=%0b MemWrite=%0b MemAddr=%h)",
               busy, MemWrite, MemAddr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_load("load14", 32'h0, 14, 0);
    run_dump("dump10", 32'd4000, 10, 0, 1'b0);
    run_load("load_toggle", 32'h100, 10, 1);
    run_dump("dump_stall", 32'h100, 10, 2, 1'b1);

    start_xfer(1'b0, 32'h40, 0);
    wait_done("count0_load", 1);
    start_xfer(1'b1, 32'h40, 0);
    wait_done("count0_dump", 1);

    // reset after 3 of 8 LOAD words
    start_xfer(1'b0, 32'h200, 8);
    acc = 0;
    while (acc < 3) begin
      in_valid = 1'b1;
      d = $urandom;
      in_data = d;
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_wr_q.push_back({32'h200 + 32'(4 * acc), d});
        ref_mem[widx(32'h200 + 32'(4 * acc))] = d;
        acc++;
      end else begin
        acc = 3;
        errors++;
        $display("FAIL rst_test_ready got in_ready=0 exp 1");
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    dc = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_data, busy, done, MemRead, MemWrite, MemAddr, WriteMem} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got nonzero exp all 0 (busy=%0b MemWrite=%0b)", busy, MemWrite);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != dc || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_no_done got done_cnt=%0d pending=%0d exp %0d 0", done_cnt, exp_wr_q.size(), dc);
      exp_wr_q.delete();
    end
    run_load("load_after_rst", 32'h300, 5, 0);

    // address wrap
    run_load("load_wrap", 32'hFFFF_FFF8, 3, 0);
    run_dump("dump_wrap", 32'hFFFF_FFFC, 3, 1, 1'b0);

    // randomized transfers (low base bits random, must be ignored)
    for (int t = 0; t < 8; t++) begin
      logic [ADDR_W-1:0] b;
      int n;
      b = 32'($urandom_range(0, WORDS - 1)) * 32'd4 + 32'($urandom_range(0, 3));
      n = $urandom_range(1, 16);
      if ($urandom_range(0, 1) == 0) run_load("rand_load", b, n, 2);
      else run_dump("rand_dump", b, n, 1, 1'b0);
    end

    // whole-memory comparison against the model
    for (int i = 0; i < WORDS; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin
        errors++;
        $display("FAIL mem_word[%0d] got %h exp %h", i, mem[i], ref_mem[i]);
      end
    end
    checks++;
    if (done_cnt != exp_done) begin
      errors++;
      $display("FAIL done_pulses got %0d exp %0d", done_cnt, exp_done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
